cam_sccb_writer: RTL
====================

Name: cam_sccb_writer

Overview:
- Consumes the divided SCCB clock from the camera SCCB clock generator and performs one 3-phase SCCB write to the OV7670: device ID, register address, register data.
- Sits between the camera register-init sequencer (upstream: start/data handshake) and the SIO_C/SIO_D pads (downstream).
- Paces all bus activity from edges of sccb_clk_i. Every edge counts as one tick, so one SCCB bit takes 4 ticks.

Parameters:
- CHECK_ACK, 0, when 1 the 9th (don't-care) bit of each phase is sampled and a high value sets nack_o; when 0, nack_o stays 0.

Ports:
- clk_i  in  1  system clock; same domain as sccb_clk_i.
- rst_i  in  1  asynchronous, active-low reset.
- sccb_clk_i  in  1  divided SCCB clock, a registered output in the clk_i domain.
- start_i  in  1  request one write; sampled only in IDLE.
- dev_addr_i  in  8  SCCB write ID (0x42 for OV7670).
- reg_addr_i  in  8  sub-address.
- reg_data_i  in  8  write data.
- siod_i  in  1  pad SIO_D readback.
- busy_o  out  1  high from start acceptance until done_o.
- done_o  out  1  one-clk_i pulse at end of transaction.
- nack_o  out  1  sticky NACK flag for the last transaction.
- sioc_o  out  1  SIO_C pad drive.
- siod_o  out  1  SIO_D drive value.
- siod_oe_o  out  1  1 = drive siod_o; 0 = release (high-Z).

Behaviour:
- Reset: clock and reset are clk_i and rst_i; rst_i is asynchronous, active-low.
- Reset values: state IDLE, sioc_o=1, siod_o=1, siod_oe_o=1, busy_o=0, done_o=0, nack_o=0, edge-detect register=0. Reset asserted mid-transaction aborts immediately to these values; no stop condition is generated.
- Tick generation: sccb_q <= sccb_clk_i each cycle; tick = sccb_q ^ sccb_clk_i. Ticks occur on both edges. At the default generator setting, ticks are 251 clk_i cycles apart.
- Start handshake:
  - In IDLE with start_i=1: latch shift register {dev_addr_i,1,reg_addr_i,1,reg_data_i,1} (27 bits, MSB first).
  - Clear nack_o, set busy_o on the next edge, enter START.
  - start_i is ignored while busy_o=1.
- START state:
  - 1st tick: siod_o<=0 (SIO_C still high).
  - 2nd tick: sioc_o<=0, bit_idx<=0, phase<=0, go to BIT.
- BIT state, 4 ticks per bit, phase 0..3:
  - p0: if bit_idx mod 9 == 8, siod_oe_o<=0; else siod_oe_o<=1 and siod_o<=shift MSB.
  - p1: sioc_o<=1.
  - p2: if 9th bit and CHECK_ACK=1 and siod_i=1, nack_o<=1.
  - p3: sioc_o<=0, shift left, bit_idx++. After bit_idx 26 completes, go to STOP.
- STOP state:
  - t0: siod_oe_o<=1, siod_o<=0.
  - t1: sioc_o<=1.
  - t2: siod_o<=1, go to DONE.
- DONE state: done_o=1 for exactly one clk_i cycle, busy_o<=0, return to IDLE. A start_i in the cycle after done_o is accepted.
- Transaction length: exactly 113 ticks from the first tick after acceptance (2+108+3). The wait for the first tick is 1 to 251 cycles, because the tick phase is free-running.
- Outputs change only on tick cycles, except busy_o, done_o and the nack_o clear.
- bit_idx is 5 bits and phase is 2 bits; phase wraps 3→0. Shift-register width is 27.
- SIO_D never changes while SIO_C is high, except the start (1→0) and stop (0→1) edges.

Test Plan:
- Reset with sccb_clk_i toggling every 4 clk_i cycles -> idle values sioc=1, siod=1, oe=1, busy=0, done=0, nack=0.
- start_i with dev 0x42, reg 0x12, data 0x80 -> start condition, then SIO_D sampled on SIO_C rising edges = 0100_0010 Z 0001_0010 Z 1000_0000 Z, then stop condition. done_o pulses once, 113 ticks after the first tick.
- CHECK_ACK=1, bench drives siod_i=1 during the 2nd 9th-bit window -> nack_o=1 at done_o. A following clean transaction clears nack_o to 0.
- start_i held high during a transaction with different data -> ignored; transaction data unchanged; a second transaction starts right after done_o.
- rst_i low at bit_idx 10 -> all outputs return to reset values asynchronously. A new start after release produces a full correct transaction.
- Protocol monitor over 20 random writes -> no SIO_D change while SIO_C is high except start/stop; busy_o is high for the whole transaction.

Source files
------------

// File: rtl/cam_sccb_writer.sv
// One 3-phase SCCB write (ID, sub-address, data) paced by edges of sccb_clk_i, 4 ticks per bit.
// 113 ticks from the first tick after start; start_i is ignored while busy_o is high.
module cam_sccb_writer #(
    parameter bit CHECK_ACK = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sccb_clk_i,
    input  logic       start_i,
    input  logic [7:0] dev_addr_i,
    input  logic [7:0] reg_addr_i,
    input  logic [7:0] reg_data_i,
    input  logic       siod_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       nack_o,
    output logic       sioc_o,
    output logic       siod_o,
    output logic       siod_oe_o
);

    typedef enum logic [2:0] {IDLE, START, BIT, STOP, DONE} state_t;

    state_t      state_q;
    logic [26:0] shift_q;
    logic [4:0]  bit_idx_q;
    logic [1:0]  phase_q;
    logic        sccb_q;
    logic        tick;
    logic        ack_bit;

    assign tick    = sccb_q ^ sccb_clk_i;
    // Every 9th bit on the wire is the slave's don't-care/ACK slot.
    assign ack_bit = (bit_idx_q == 5'd8) || (bit_idx_q == 5'd17) || (bit_idx_q == 5'd26);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            phase_q   <= '0;
            sccb_q    <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            nack_o    <= 1'b0;
            sioc_o    <= 1'b1;
            siod_o    <= 1'b1;
            siod_oe_o <= 1'b1;
        end else begin
            sccb_q <= sccb_clk_i;
            done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        shift_q <= {dev_addr_i, 1'b1, reg_addr_i, 1'b1, reg_data_i, 1'b1};
                        nack_o  <= 1'b0;
                        busy_o  <= 1'b1;
                        phase_q <= 2'd0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (phase_q == 2'd0) begin
                            siod_o  <= 1'b0;
                            phase_q <= 2'd1;
                        end else begin
                            sioc_o    <= 1'b0;
                            bit_idx_q <= 5'd0;
                            phase_q   <= 2'd0;
                            state_q   <= BIT;
                        end
                    end
                end
                BIT: begin
                    if (tick) begin
                        phase_q <= phase_q + 2'd1;
                        case (phase_q)
                            2'd0: begin
                                if (ack_bit) begin
                                    siod_oe_o <= 1'b0;
                                end else begin
                                    siod_oe_o <= 1'b1;
                                    siod_o    <= shift_q[26];
                                end
                            end
                            2'd1: sioc_o <= 1'b1;
                            2'd2: begin
                                if (CHECK_ACK && ack_bit && siod_i)
                                    nack_o <= 1'b1;
                            end
                            default: begin
                                sioc_o    <= 1'b0;
                                shift_q   <= {shift_q[25:0], 1'b0};
                                bit_idx_q <= bit_idx_q + 5'd1;
                                if (bit_idx_q == 5'd26)
                                    state_q <= STOP;
                            end
                        endcase
                    end
                end
                STOP: begin
                    if (tick) begin
                        case (phase_q)
                            2'd0: begin
                                siod_oe_o <= 1'b1;
                                siod_o    <= 1'b0;
                                phase_q   <= 2'd1;
                            end
                            2'd1: begin
                                sioc_o  <= 1'b1;
                                phase_q <= 2'd2;
                            end
                            default: begin
                                siod_o  <= 1'b1;
                                state_q <= DONE;
                            end
                        endcase
                    end
                end
                DONE: begin
                    done_o  <= 1'b1;
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
